// File: rtl/jtframe_ram_arbn_if.sv
// Signal bundle between the per-slot request modules, the SDRAM bank arbiter and the
// SDRAM controller bank port. master = arbiter side, slave = slots/controller side.
interface jtframe_ram_arbn_if #(
  parameter int SDRAMW = 22,
  parameter int SLOTS  = 6
);
  logic [SLOTS-1:0]        req;
  logic [SLOTS-1:0]        req_rnw;
  logic [SLOTS*SDRAMW-1:0] slot_addr;
  logic [SLOTS*16-1:0]     slot_din;
  logic [SLOTS*2-1:0]      slot_wrmask;
  logic [SLOTS-1:0]        slot_sel;
  logic                    sdram_ack;
  logic                    data_rdy;
  logic                    sdram_rd;
  logic                    sdram_wr;
  logic [SDRAMW-1:0]       sdram_addr;
  logic [15:0]             data_write;
  logic [1:0]              sdram_wrmask;
  logic                    timeout;

  modport master (
    input  req, req_rnw, slot_addr, slot_din, slot_wrmask, sdram_ack, data_rdy,
    output slot_sel, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask, timeout
  );

  modport slave (
    output req, req_rnw, slot_addr, slot_din, slot_wrmask, sdram_ack, data_rdy,
    input  slot_sel, sdram_rd, sdram_wr, sdram_addr, data_write, sdram_wrmask, timeout
  );
endinterface

// File: rtl/jtframe_ram_arbn.sv
// SDRAM bank arbiter for SLOTS request slots with per-slot write enable and a transaction watchdog.
// Define JTFRAME_RAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, slot 0 highest.
module jtframe_ram_arbn #(
  parameter int         SDRAMW  = 22,
  parameter int         SLOTS   = 6,
  parameter logic [7:0] WRSLOTS = 8'h03,
  parameter int         TIMEOUT = 255
) (
  input  logic                 rst,
  input  logic                 clk,
  jtframe_ram_arbn_if.master   bus
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  localparam logic [9:0] WD_LAST = (TIMEOUT == 0) ? 10'd0 : 10'(TIMEOUT - 1);

  state_t            state, next_state;
  logic [SLOTS-1:0]  sel, next_sel;
  logic [SLOTS-1:0]  active;
  logic              rd, next_rd;
  logic              wr, next_wr;
  logic              to, next_to;
  logic [SDRAMW-1:0] addr, next_addr;
  logic [15:0]       dout, next_dout;
  logic [1:0]        mask, next_mask;
  logic [9:0]        wd, next_wd;
  logic              win_vld;
  logic              win_rnw;
  int                win_i;
`ifdef JTFRAME_RAM_ARB_RR_EN
  logic [2:0]        rr_ptr, next_ptr;
`endif

  // The slot currently owning the bank cannot win again in its own completion cycle
  assign active = bus.req & ~sel;

  always_comb begin
`ifdef JTFRAME_RAM_ARB_RR_EN
    int j;
`endif
    win_vld = 1'b0;
    win_i   = 0;
`ifdef JTFRAME_RAM_ARB_RR_EN
    j = 0;
    for (int k = 1; k <= SLOTS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= SLOTS) j = j - SLOTS;
      if (!win_vld && active[j]) begin
        win_vld = 1'b1;
        win_i   = j;
      end
    end
`else
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_vld = 1'b1;
        win_i   = i;
      end
    end
`endif
    // Slots outside WRSLOTS are always treated as readers
    win_rnw = bus.req_rnw[win_i] | ~WRSLOTS[win_i];
  end

  always_comb begin
    next_state = state;
    next_sel   = sel;
    next_rd    = rd;
    next_wr    = wr;
    next_to    = 1'b0;
    next_addr  = addr;
    next_dout  = dout;
    next_mask  = mask;
    next_wd    = wd;
`ifdef JTFRAME_RAM_ARB_RR_EN
    next_ptr   = rr_ptr;
`endif
    if (state == IDLE || bus.data_rdy) begin
      next_wd = 10'd0;
      if (win_vld) begin
        next_state      = CMD;
        next_sel        = '0;
        next_sel[win_i] = 1'b1;
        next_rd         = win_rnw;
        next_wr         = ~win_rnw;
        next_addr       = bus.slot_addr[win_i*SDRAMW +: SDRAMW];
        next_dout       = bus.slot_din[win_i*16 +: 16];
        next_mask       = win_rnw ? 2'b11 : bus.slot_wrmask[win_i*2 +: 2];
`ifdef JTFRAME_RAM_ARB_RR_EN
        next_ptr        = 3'(win_i);
`endif
      end else begin
        next_state = IDLE;
        next_sel   = '0;
        next_rd    = 1'b0;
        next_wr    = 1'b0;
      end
    end else if (TIMEOUT != 0 && wd == WD_LAST) begin
      // Watchdog abort: the controller never reported completion
      next_state = IDLE;
      next_sel   = '0;
      next_rd    = 1'b0;
      next_wr    = 1'b0;
      next_to    = 1'b1;
      next_wd    = 10'd0;
    end else begin
      next_wd = wd + 10'd1;
      if (state == CMD && bus.sdram_ack) begin
        next_state = WAIT;
        next_rd    = 1'b0;
        next_wr    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      to     <= 1'b0;
      addr   <= '0;
      dout   <= 16'd0;
      mask   <= 2'b11;
      wd     <= 10'd0;
`ifdef JTFRAME_RAM_ARB_RR_EN
      rr_ptr <= 3'(SLOTS - 1);
`endif
    end else begin
      state  <= next_state;
      sel    <= next_sel;
      rd     <= next_rd;
      wr     <= next_wr;
      to     <= next_to;
      addr   <= next_addr;
      dout   <= next_dout;
      mask   <= next_mask;
      wd     <= next_wd;
`ifdef JTFRAME_RAM_ARB_RR_EN
      rr_ptr <= next_ptr;
`endif
    end
  end

  assign bus.slot_sel     = sel;
  assign bus.sdram_rd     = rd;
  assign bus.sdram_wr     = wr;
  assign bus.sdram_addr   = addr;
  assign bus.data_write   = dout;
  assign bus.sdram_wrmask = mask;
  assign bus.timeout      = to;

endmodule

// File: tb/tb_jtframe_ram_arbn.sv
// Testbench for jtframe_ram_arbn: directed scenarios followed by random traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_jtframe_ram_arbn;
  localparam int         SDRAMW  = 22;
  localparam int         SLOTS   = 6;
  localparam logic [7:0] WRSLOTS = 8'h03;
  localparam int         TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  // Reference model: who owns the bank, how long it has owned it, and what the bus should show
  int                owner;
  int                age;
  int                last;
  logic [SLOTS-1:0]  m_sel;
  logic              m_rd, m_wr, m_to;
  logic [SDRAMW-1:0] m_addr;
  logic [15:0]       m_dw;
  logic [1:0]        m_mask;
  bit                dw_care;

  jtframe_ram_arbn_if #(.SDRAMW(SDRAMW), .SLOTS(SLOTS)) bus ();

  jtframe_ram_arbn #(
    .SDRAMW (SDRAMW),
    .SLOTS  (SLOTS),
    .WRSLOTS(WRSLOTS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .rst(rst),
    .clk(clk),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [SLOTS-1:0] elig, input int from);
`ifdef JTFRAME_RAM_ARB_RR_EN
    for (int k = 1; k <= SLOTS; k++)
      if (elig[(from + k) % SLOTS]) return (from + k) % SLOTS;
`else
    for (int i = 0; i < SLOTS; i++)
      if (elig[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_edge();
    int  win;
    bit  is_read;
    if (rst) begin
      owner = -1; age = 0; last = SLOTS - 1;
      m_sel = '0; m_rd = 0; m_wr = 0; m_to = 0;
      m_addr = '0; m_dw = '0; m_mask = 2'b11; dw_care = 1;
      return;
    end
    m_to = 0;
    if (owner < 0 || bus.data_rdy) begin
      win = pick(bus.req & ~m_sel, last);
      age = 0;
      if (win >= 0) begin
        is_read = bus.req_rnw[win] || !WRSLOTS[win];
        owner   = win;
        last    = win;
        m_rd    = is_read;
        m_wr    = !is_read;
        m_addr  = bus.slot_addr[win*SDRAMW +: SDRAMW];
        m_dw    = bus.slot_din[win*16 +: 16];
        m_mask  = is_read ? 2'b11 : bus.slot_wrmask[win*2 +: 2];
        dw_care = !is_read;
      end else begin
        owner = -1; m_rd = 0; m_wr = 0;
      end
    end else if (age + 1 == TIMEOUT) begin
      owner = -1; m_rd = 0; m_wr = 0; m_to = 1; age = 0;
    end else begin
      age++;
      if (bus.sdram_ack) begin m_rd = 0; m_wr = 0; end
    end
    m_sel = (owner < 0) ? '0 : SLOTS'(1) << owner;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".slot_sel"}, 32'(bus.slot_sel), 32'(m_sel));
    chk({tag, ".sdram_rd"}, 32'(bus.sdram_rd), 32'(m_rd));
    chk({tag, ".sdram_wr"}, 32'(bus.sdram_wr), 32'(m_wr));
    chk({tag, ".sdram_addr"}, 32'(bus.sdram_addr), 32'(m_addr));
    chk({tag, ".wrmask"}, 32'(bus.sdram_wrmask), 32'(m_mask));
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(m_to));
    if (dw_care) chk({tag, ".data_write"}, 32'(bus.data_write), 32'(m_dw));
  endtask

  task automatic applyStimulus(input logic r, input logic [SLOTS-1:0] rq,
                               input logic [SLOTS-1:0] rnw, input logic ack, input logic rdy,
                               input string tag);
    rst           = r;
    bus.req       = rq;
    bus.req_rnw   = rnw;
    bus.sdram_ack = ack;
    bus.data_rdy  = rdy;
    model_edge();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic randomize_slots();
    for (int s = 0; s < SLOTS; s++) begin
      bus.slot_addr[s*SDRAMW +: SDRAMW] = SDRAMW'($urandom);
      bus.slot_din[s*16 +: 16]          = 16'($urandom);
      bus.slot_wrmask[s*2 +: 2]         = 2'($urandom);
    end
  endtask

  initial begin
    bus.req = '0; bus.req_rnw = '1; bus.sdram_ack = 0; bus.data_rdy = 0;
    randomize_slots();

    applyStimulus(1, '0, '1, 0, 0, "reset0");
    applyStimulus(1, 6'b000100, '1, 1, 1, "reset1");
    chk("reset.slot_sel", 32'(bus.slot_sel), 32'h0);
    chk("reset.wrmask", 32'(bus.sdram_wrmask), 32'h3);
    chk("reset.data_write", 32'(bus.data_write), 32'h0);
    chk("reset.sdram_addr", 32'(bus.sdram_addr), 32'h0);

    // Reset while slot 2 is waiting for data
    applyStimulus(0, 6'b000100, '1, 0, 0, "rstwait.grant");
    chk("rstwait.sel", 32'(bus.slot_sel), 32'h04);
    chk("rstwait.rd", 32'(bus.sdram_rd), 32'h1);
    applyStimulus(0, 6'b000100, '1, 1, 0, "rstwait.ack");
    chk("rstwait.rd_after_ack", 32'(bus.sdram_rd), 32'h0);
    applyStimulus(1, 6'b000100, '1, 0, 0, "rstwait.rst");
    chk("rstwait.sel_clr", 32'(bus.slot_sel), 32'h0);
    chk("rstwait.strobes", {30'd0, bus.sdram_rd, bus.sdram_wr}, 32'h0);
    chk("rstwait.mask", 32'(bus.sdram_wrmask), 32'h3);
    chk("rstwait.timeout", 32'(bus.timeout), 32'h0);

    // Priority with slots 1, 2 and 5 requesting continuously
    applyStimulus(0, 6'b100110, '1, 0, 0, "prio.g1");
    chk("prio.order1", 32'(bus.slot_sel), 32'h02);
    applyStimulus(0, 6'b100110, '1, 0, 1, "prio.g2");
    chk("prio.order2", 32'(bus.slot_sel), 32'h04);
    applyStimulus(0, 6'b100110, '1, 0, 1, "prio.g3");
`ifdef JTFRAME_RAM_ARB_RR_EN
    chk("prio.order3", 32'(bus.slot_sel), 32'h20);
`else
    chk("prio.order3", 32'(bus.slot_sel), 32'h02);
`endif
    applyStimulus(0, 6'b100110, '1, 0, 1, "prio.g4");
`ifdef JTFRAME_RAM_ARB_RR_EN
    chk("prio.order4", 32'(bus.slot_sel), 32'h02);
`else
    chk("prio.order4", 32'(bus.slot_sel), 32'h04);
`endif
    applyStimulus(0, '0, '1, 0, 1, "prio.drain");

    // Write from a writing slot, then a forced read from a non-writing slot
    bus.slot_addr[0 +: SDRAMW] = 22'h1234;
    bus.slot_din[0 +: 16]      = 16'hABCD;
    bus.slot_wrmask[0 +: 2]    = 2'b10;
    applyStimulus(0, 6'b000001, 6'b111110, 0, 0, "wr.slot0");
    chk("wr.wr", 32'(bus.sdram_wr), 32'h1);
    chk("wr.rd", 32'(bus.sdram_rd), 32'h0);
    chk("wr.data", 32'(bus.data_write), 32'hABCD);
    chk("wr.mask", 32'(bus.sdram_wrmask), 32'h2);
    chk("wr.addr", 32'(bus.sdram_addr), 32'h1234);
    applyStimulus(0, 6'b001000, 6'b110110, 0, 1, "wr.slot3");
    chk("wr.forced_rd", 32'(bus.sdram_rd), 32'h1);
    chk("wr.forced_wr", 32'(bus.sdram_wr), 32'h0);
    chk("wr.forced_mask", 32'(bus.sdram_wrmask), 32'h3);
    applyStimulus(0, '0, '1, 0, 1, "wr.drain");

    // Watchdog expiry on slot 1
    applyStimulus(0, 6'b000010, '1, 0, 0, "wd.grant");
    applyStimulus(0, '0, '1, 1, 0, "wd.ack");
    for (int k = 2; k < TIMEOUT; k++) applyStimulus(0, '0, '1, 0, 0, "wd.wait");
    chk("wd.still_owned", 32'(bus.slot_sel), 32'h02);
    chk("wd.no_pulse_yet", 32'(bus.timeout), 32'h0);
    applyStimulus(0, '0, '1, 0, 0, "wd.expire");
    chk("wd.pulse", 32'(bus.timeout), 32'h1);
    chk("wd.sel_clr", 32'(bus.slot_sel), 32'h0);
    applyStimulus(0, '0, '1, 0, 0, "wd.after");
    chk("wd.pulse_end", 32'(bus.timeout), 32'h0);

    // data_rdy arriving on the watchdog's last cycle completes normally
    applyStimulus(0, 6'b000010, '1, 0, 0, "wd2.grant");
    applyStimulus(0, '0, '1, 1, 0, "wd2.ack");
    for (int k = 2; k < TIMEOUT; k++) applyStimulus(0, '0, '1, 0, 0, "wd2.wait");
    applyStimulus(0, '0, '1, 0, 1, "wd2.rdy");
    chk("wd2.no_pulse", 32'(bus.timeout), 32'h0);
    chk("wd2.sel_clr", 32'(bus.slot_sel), 32'h0);

    // Back-to-back hand-over from slot 0 to slot 4
    applyStimulus(0, 6'b000001, '1, 0, 0, "b2b.g0");
    chk("b2b.first", 32'(bus.slot_sel), 32'h01);
    applyStimulus(0, 6'b010001, '1, 1, 0, "b2b.ack");
    applyStimulus(0, 6'b010001, '1, 0, 1, "b2b.rdy");
    chk("b2b.next", 32'(bus.slot_sel), 32'h10);
    chk("b2b.rd", 32'(bus.sdram_rd), 32'h1);
    applyStimulus(0, '0, '1, 0, 1, "b2b.drain");

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      randomize_slots();
      applyStimulus(($urandom_range(0, 199) == 0), SLOTS'($urandom) & SLOTS'($urandom),
                    SLOTS'($urandom), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 4) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
